// File: rtl/tt_uio_uart_tx_if.sv
// Byte handshake between the ui_in byte source and the UART transmitter.
// The master offers data_in/data_valid; the slave answers with data_ready.
interface tt_uio_uart_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/tt_uio_uart_tx.sv
// UART 8N1 transmitter for the tile's uio pin: accepts a byte over a valid/ready
// handshake and shifts it out LSB first, with start and stop bits.
module tt_uio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  tt_uio_uart_tx_if.slave         byte_if,
  output logic                    txd,
  output logic                    txd_oe,
  output logic                    busy,
  output logic [7:0]              bytes_sent
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            txd_q;
  logic            txd_oe_q;
  logic            busy_q;
  logic [7:0]      bytes_sent_q;
  logic            accept;
  logic            bit_end;

  assign byte_if.data_ready = (state_q == StIdle) && ena && !rst;
  assign accept             = byte_if.data_valid && byte_if.data_ready;
  assign bit_end            = (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      txd_q        <= 1'b1;
      txd_oe_q     <= 1'b1;
      busy_q       <= 1'b0;
      bytes_sent_q <= '0;
    end else begin
      txd_oe_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q   <= byte_if.data_in;
            state_q   <= StStart;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StData;
            txd_q   <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              txd_q   <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              // shreg_q still holds the current bit in [0], so the next one is [1]
              txd_q     <= shreg_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q        <= '0;
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            bytes_sent_q <= bytes_sent_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign txd        = txd_q;
  assign txd_oe     = txd_oe_q;
  assign busy       = busy_q;
  assign bytes_sent = bytes_sent_q;

endmodule
